// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: prefetching IF stage with a DEPTH-entry fetch FIFO.
// Ports: Clk/Rst; InstReq/InstAddr request; InstValid/Instruction response;
// Redirect/RedirectAddr branch; Stall from ID; *_id head outputs; Count/Full/Empty.
module inst_fetch_queue #(
  parameter int WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
  parameter int PC_INC = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                  Clk,
  input  logic                  Rst,
  output logic                  InstReq,
  output logic [ADDR_WIDTH-1:0] InstAddr,
  input  logic                  InstValid,
  input  logic [WIDTH-1:0]      Instruction,
  input  logic                  Redirect,
  input  logic [ADDR_WIDTH-1:0] RedirectAddr,
  input  logic                  Stall,
  output logic                  Valid_id,
  output logic [WIDTH-1:0]      Instruction_id,
  output logic [ADDR_WIDTH-1:0] PcAdderOut_id,
  output logic [CNT_W-1:0]      Count,
  output logic                  Full,
  output logic                  Empty
);

  localparam int PW = $clog2(DEPTH);

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [PW-1:0]         wr_q, wr_d;
  logic [PW-1:0]         rd_q, rd_d;
  logic [PW-1:0]         tw_q, tw_d;
  logic [PW-1:0]         tr_q, tr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [CNT_W-1:0]      outst_q, outst_d;
  logic [CNT_W-1:0]      drop_q, drop_d;
  logic [WIDTH-1:0]      inst_q, inst_d;
  logic [ADDR_WIDTH-1:0] pcid_q, pcid_d;

  logic [WIDTH-1:0]      dmem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] fmem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] tag_q  [DEPTH];

  logic [CNT_W:0]        credit;
  logic                  issue;
  logic                  dropping;
  logic                  push;
  logic                  pop;
  logic [ADDR_WIDTH-1:0] pc_next;

  assign pc_next  = pc_q + ADDR_WIDTH'(PC_INC);
  // FIFO entries plus in-flight words may never exceed DEPTH,
  // so a returning word always finds a free slot.
  assign credit   = {1'b0, count_q} + {1'b0, outst_q};
  assign issue    = !Rst && !Redirect
                  && (credit < (CNT_W+1)'(DEPTH));
  assign dropping = InstValid && (drop_q != '0);
  assign push     = InstValid && !dropping
                  && !Redirect && !Rst;
  assign pop      = (count_q != '0) && !Stall
                  && !Redirect;

  assign InstReq        = issue;
  assign InstAddr       = pc_q;
  assign Valid_id       = (count_q != '0);
  assign Empty          = (count_q == '0);
  assign Full           = (count_q == CNT_W'(DEPTH));
  assign Count          = count_q;
  assign Instruction_id = inst_q;
  assign PcAdderOut_id  = pcid_q;

  always_comb begin
    pc_d    = pc_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    tw_d    = tw_q;
    tr_d    = tr_q;
    count_d = count_q;
    outst_d = outst_q;
    drop_d  = drop_q;
    inst_d  = inst_q;
    pcid_d  = pcid_q;

    if (issue) begin
      pc_d = pc_next;
      tw_d = tw_q + PW'(1);
    end
    // every response, kept or dropped, consumes one tag
    if (InstValid) tr_d = tr_q + PW'(1);

    if (Redirect) begin
      pc_d    = RedirectAddr;
      count_d = '0;
      wr_d    = '0;
      rd_d    = '0;
      // the word arriving now is discarded with the rest
      outst_d = outst_q - CNT_W'(InstValid);
      drop_d  = outst_q - CNT_W'(InstValid);
    end else begin
      outst_d = outst_q + CNT_W'(issue)
              - CNT_W'(InstValid);
      if (dropping) drop_d = drop_q - CNT_W'(1);
      if (push) wr_d = wr_q + PW'(1);
      if (pop) rd_d = rd_q + PW'(1);
      count_d = count_q + CNT_W'(push)
              - CNT_W'(pop);
    end

    // register the next head; a word pushed into an
    // otherwise empty slot comes straight from the port
    if (!Redirect && count_d != '0) begin
      if (push && wr_q == rd_d) begin
        inst_d = Instruction;
        pcid_d = tag_q[tr_q];
      end else begin
        inst_d = dmem_q[rd_d];
        pcid_d = fmem_q[rd_d];
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      pc_q    <= RESET_PC;
      wr_q    <= '0;
      rd_q    <= '0;
      tw_q    <= '0;
      tr_q    <= '0;
      count_q <= '0;
      outst_q <= '0;
      drop_q  <= '0;
      inst_q  <= '0;
      pcid_q  <= '0;
    end else begin
      pc_q    <= pc_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      tw_q    <= tw_d;
      tr_q    <= tr_d;
      count_q <= count_d;
      outst_q <= outst_d;
      drop_q  <= drop_d;
      inst_q  <= inst_d;
      pcid_q  <= pcid_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (issue) tag_q[tw_q] <= pc_next;
    if (push) begin
      dmem_q[wr_q] <= Instruction;
      fmem_q[wr_q] <= tag_q[tr_q];
    end
  end

endmodule
